// File: rtl/quad_encoder_emulator_if.sv
// rtl/quad_encoder_emulator_if.sv - command and encoder output bundle for the quadrature encoder emulator
interface quad_encoder_emulator_if #(
    parameter int CNT_W = 21,
    parameter int DIV_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_target;
    logic [DIV_W-1:0] cmd_period;
    logic             A;
    logic             B;
    logic             Z;
    logic [CNT_W-1:0] position;
    logic             busy;
    logic             done;

    // Command issuer: drives requests, observes the emulated encoder
    modport master (
        output cmd_valid, cmd_target, cmd_period,
        input  cmd_ready, A, B, Z, position, busy, done
    );

    // Emulator side
    modport slave (
        input  cmd_valid, cmd_target, cmd_period,
        output cmd_ready, A, B, Z, position, busy, done
    );
endinterface

// File: rtl/quad_encoder_emulator.sv
// rtl/quad_encoder_emulator.sv - walks a position toward a commanded target emitting A/B/Z quadrature
module quad_encoder_emulator #(
    parameter int CNT_W = 21,
    parameter int DIV_W = 16,
    parameter int CPR   = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    quad_encoder_emulator_if.slave bus
);
    localparam int REV_W = $clog2(CPR);
    localparam logic [REV_W-1:0] REV_MAX = REV_W'(CPR - 1);

    typedef enum logic {IDLE, MOVE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic [REV_W-1:0] rev_q, rev_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic [DIV_W-1:0] per_q, per_d;
    logic [DIV_W-1:0] tmr_q, tmr_d;
    logic             dir_q, dir_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             z_q, z_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] diff;
    logic [DIV_W-1:0] per_eff;

    // State and output registers; reset parks the encoder at index with A=B=0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pos_q   <= '0;
            rev_q   <= '0;
            tgt_q   <= '0;
            per_q   <= DIV_W'(1);
            tmr_q   <= '0;
            dir_q   <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            z_q     <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            rev_q   <= rev_d;
            tgt_q   <= tgt_d;
            per_q   <= per_d;
            tmr_q   <= tmr_d;
            dir_q   <= dir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    // Next state: accept commands in IDLE, step on timer expiry in MOVE; A/B/Z follow the next position
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        rev_d   = rev_q;
        tgt_d   = tgt_q;
        per_d   = per_q;
        tmr_d   = tmr_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        per_eff = (bus.cmd_period == '0) ? DIV_W'(1) : bus.cmd_period;
        diff    = bus.cmd_target - pos_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (diff == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = MOVE;
                        tgt_d   = bus.cmd_target;
                        per_d   = per_eff;
                        tmr_d   = per_eff - DIV_W'(1);
                        // Sign bit clear means strictly positive here; the most negative
                        // difference has the sign bit set and therefore decrements.
                        dir_d   = ~diff[CNT_W-1];
                    end
                end
            end
            MOVE: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - DIV_W'(1);
                end else begin
                    tmr_d = per_q - DIV_W'(1);
                    if (dir_q) begin
                        pos_d = pos_q + CNT_W'(1);
                        rev_d = (rev_q == REV_MAX) ? '0 : rev_q + REV_W'(1);
                    end else begin
                        pos_d = pos_q - CNT_W'(1);
                        rev_d = (rev_q == '0) ? REV_MAX : rev_q - REV_W'(1);
                    end
                    if (pos_d == tgt_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Gray phase from the low two count bits: 0->00, 1->10, 2->11, 3->01
        a_d = pos_d[1] ^ pos_d[0];
        b_d = pos_d[1];
        z_d = (rev_d == '0);
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q == MOVE);
    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.Z         = z_q;
    assign bus.position  = pos_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_quad_encoder_emulator.sv
// tb/tb_quad_encoder_emulator.sv - directed vectors for quad_encoder_emulator
module tb_quad_encoder_emulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    quad_encoder_emulator_if #(.CNT_W(21), .DIV_W(16)) ifa ();
    quad_encoder_emulator_if #(.CNT_W(4),  .DIV_W(16)) ifb ();

    quad_encoder_emulator #(.CNT_W(21), .DIV_W(16), .CPR(8)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave)
    );
    quad_encoder_emulator #(.CNT_W(4), .DIV_W(16), .CPR(8)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave)
    );

    logic [1:0] ph [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic issue_a(input logic [20:0] tgt, input logic [15:0] per);
        @(negedge clk);
        ifa.cmd_valid  = 1'b1;
        ifa.cmd_target = tgt;
        ifa.cmd_period = per;
        @(posedge clk);
        #1;
        ifa.cmd_valid = 1'b0;
    endtask

    task automatic issue_b(input logic [3:0] tgt, input logic [15:0] per);
        @(negedge clk);
        ifb.cmd_valid  = 1'b1;
        ifb.cmd_target = tgt;
        ifb.cmd_period = per;
        @(posedge clk);
        #1;
        ifb.cmd_valid = 1'b0;
    endtask

    task automatic wait_done_a(input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(posedge clk);
            #1;
            if (ifa.done) seen = 1'b1;
        end
        check("done_timeout", 32'(seen), 32'd1);
    endtask

    initial begin
        int ep;
        int dcount;
        int wp [3];
        ph[0] = 2'b00; ph[1] = 2'b10; ph[2] = 2'b11; ph[3] = 2'b01;
        ifa.cmd_valid = 1'b0; ifa.cmd_target = '0; ifa.cmd_period = '0;
        ifb.cmd_valid = 1'b0; ifb.cmd_target = '0; ifb.cmd_period = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_A",     32'(ifa.A), 32'd0);
        check("rst_B",     32'(ifa.B), 32'd0);
        check("rst_Z",     32'(ifa.Z), 32'd1);
        check("rst_pos",   32'(ifa.position), 32'd0);
        check("rst_busy",  32'(ifa.busy), 32'd0);
        check("rst_done",  32'(ifa.done), 32'd0);
        check("rst_ready", 32'(ifa.cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // target 8, period 4: steps at +4..+32, Z leaves at +4 and returns at +32
        issue_a(21'd8, 16'd4);
        check("t1_busy", 32'(ifa.busy), 32'd1);
        check("t1_ready", 32'(ifa.cmd_ready), 32'd0);
        for (int c = 1; c <= 33; c++) begin
            @(posedge clk);
            #1;
            ep = (c / 4 > 8) ? 8 : c / 4;
            check("t1_pos",  32'(ifa.position), 32'(ep));
            check("t1_ab",   32'({ifa.A, ifa.B}), 32'(ph[ep % 4]));
            check("t1_z",    32'(ifa.Z), 32'(ep % 8 == 0));
            check("t1_done", 32'(ifa.done), 32'(c == 32));
            check("t1_busy", 32'(ifa.busy), 32'(c < 32));
        end

        // 8 -> 5 with period 0 (one count per cycle), decrement phase order
        issue_a(21'd5, 16'd0);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            check("t2_pos",  32'(ifa.position), 32'(8 - c));
            check("t2_ab",   32'({ifa.A, ifa.B}), 32'(ph[(8 - c) % 4]));
            check("t2_z",    32'(ifa.Z), 32'd0);
            check("t2_done", 32'(ifa.done), 32'(c == 3));
        end
        @(posedge clk);
        #1;
        check("t2_done_clr", 32'(ifa.done), 32'd0);

        // same target: immediate done, nothing moves
        issue_a(21'd5, 16'd3);
        check("t4_done",  32'(ifa.done), 32'd1);
        check("t4_busy",  32'(ifa.busy), 32'd0);
        check("t4_ready", 32'(ifa.cmd_ready), 32'd1);
        check("t4_ab",    32'({ifa.A, ifa.B}), 32'b10);
        check("t4_z",     32'(ifa.Z), 32'd0);
        check("t4_pos",   32'(ifa.position), 32'd5);
        @(posedge clk);
        #1;
        check("t4_done_clr", 32'(ifa.done), 32'd0);
        check("t4_busy2",    32'(ifa.busy), 32'd0);

        // valid held high through a 10-step move; second command waits for ready
        @(negedge clk);
        ifa.cmd_valid  = 1'b1;
        ifa.cmd_target = 21'd15;
        ifa.cmd_period = 16'd1;
        @(posedge clk);
        #1;
        check("t5_busy", 32'(ifa.busy), 32'd1);
        ifa.cmd_target = 21'd3;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            check("t5_pos", 32'(ifa.position), 32'(5 + c));
        end
        check("t5_done",  32'(ifa.done), 32'd1);
        check("t5_ready", 32'(ifa.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        check("t5_accept", 32'(ifa.busy), 32'd1);
        check("t5_pos15",  32'(ifa.position), 32'd15);
        ifa.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t5_first_dec", 32'(ifa.position), 32'd14);
        wait_done_a(20);
        check("t5_final", 32'(ifa.position), 32'd3);

        // wrap-around on 4-bit counter
        issue_b(4'd14, 16'd1);
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk);
            #1;
            check("w0_pos", 32'(ifb.position), 32'(16 - c));
        end
        check("w0_done", 32'(ifb.done), 32'd1);
        wp[0] = 15; wp[1] = 0; wp[2] = 1;
        issue_b(4'd1, 16'd1);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            check("w1_pos", 32'(ifb.position), 32'(wp[c - 1]));
            check("w1_ab",  32'({ifb.A, ifb.B}), 32'(ph[wp[c - 1] % 4]));
        end
        check("w1_done", 32'(ifb.done), 32'd1);
        issue_b(4'd9, 16'd1);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            check("w2_pos", 32'(ifb.position), 32'((17 - c) % 16));
        end
        check("w2_done", 32'(ifb.done), 32'd1);

        // reset in the middle of a 10-step move (3 -> 13, period 2)
        issue_a(21'd13, 16'd2);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            check("t6_pos", 32'(ifa.position), 32'(3 + c / 2));
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_A",    32'(ifa.A), 32'd0);
        check("t6_B",    32'(ifa.B), 32'd0);
        check("t6_Z",    32'(ifa.Z), 32'd1);
        check("t6_pos0", 32'(ifa.position), 32'd0);
        check("t6_busy", 32'(ifa.busy), 32'd0);
        check("t6_done", 32'(ifa.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (ifa.done) dcount++;
        end
        check("t6_no_done", 32'(dcount), 32'd0);
        check("t6_idle",    32'(ifa.position), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
